uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 7-bit UART transmitter between NUM_REQ independent requesters.
- Connects to the transmitter's data_out, data_sign, data_valid and uart_ctl pins.
- Holds the granted character and the baud selection stable for the whole frame, then acknowledges the requester.
- A watchdog aborts a frame if the transmitter never answers.

Parameters:
- NUM_REQ, 4, number of requesters.
- IDX_W, 2, width of grant index; equals clog2(NUM_REQ).
- TO_W, 17, width of watchdog counter.
- TIMEOUT, 17'd100000, watchdog limit in clk cycles per frame; covers one 9600-baud frame plus start alignment.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request per channel; held high until req_ack or timeout_err.
- req_data  in  7*NUM_REQ  character per channel; channel i uses bits [7i+6:7i]; held with req.
- req_ack  out  NUM_REQ  one-cycle pulse when channel's character has fully transmitted.
- cfg_baud  in  3  baud code 0..5 (9600..256000); sampled only at grant.
- uart_ctl  out  3  baud code to transmitter.
- data_out  out  7  character to transmitter.
- data_sign  out  1  one-cycle start strobe to transmitter.
- data_valid  in  1  transmitter idle/ready; low while a frame is in flight.
- busy  out  1  high in any state except IDLE.
- grant_id  out  IDX_W  index of current or last granted channel.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values: req_ack=0, uart_ctl=0, data_out=7'h00, data_sign=0, busy=0, grant_id=0, timeout_err=0, rr pointer=0, state=IDLE.
- State machine: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: grant only when data_valid==1 and |req. The transmitter reports data_valid=0 for one cycle after reset, so nothing is granted then.
- Round-robin selection: first asserted req at or after the rr pointer, scanning upward with wrap from NUM_REQ-1 to 0.
- On grant, in the same edge: latch grant_id, data_out<=req_data slice, uart_ctl<=cfg_baud; go to ISSUE.
- ISSUE: data_sign=1 for exactly this one cycle; clear watchdog; go to WAIT_BUSY.
- WAIT_BUSY: wait for data_valid==0, which normally arrives the cycle after the strobe; then go to WAIT_DONE.
- WAIT_DONE: wait for data_valid==1; then go to DONE.
- DONE: pulse req_ack[grant_id] for 1 cycle; rr pointer<=grant_id+1, wrapping to 0; go to IDLE.
- Minimum gap between consecutive strobes: 1 idle cycle (DONE→IDLE→grant→ISSUE).
- data_out and uart_ctl change only on a grant edge. They are constant from ISSUE through DONE. cfg_baud changes mid-frame take effect at the next grant.
- Watchdog: counts every cycle in WAIT_BUSY/WAIT_DONE and saturates at TIMEOUT.
- On reaching TIMEOUT: pulse timeout_err, no req_ack, rr pointer<=grant_id+1, return to IDLE. The requester keeps req high and is re-arbitrated later.
- A requester dropping req mid-frame does not abort the frame; its req_ack still pulses.
- A requester may re-assert req in the cycle after its ack. Round robin still serves any other pending channel first.
- NUM_REQ=1 degenerates to a sequencer with pointer fixed at 0.
- Reset asserted mid-frame clears all state immediately. data_sign is forced to 0; the transmitter's own reset recovers the line.

Test Plan:
- After reset, req=4'b0001, req_data[6:0]=7'h55, cfg_baud=4, tx model: data_valid low 1 cycle after strobe, high 9×435 cycles later → one data_sign pulse. data_out=7'h55 and uart_ctl=4 stable throughout. req_ack=4'b0001 one cycle after data_valid rises. busy then 0.
- req=4'b1111 held continuously, channel data 7'h11/22/33/44 → grant order 0,1,2,3,0 with data_out matching. Exactly one data_sign per frame.
- rr pointer at 2, req=4'b1001 → channel 3 granted before channel 0.
- cfg_baud switched 0→5 while channel 1 is in WAIT_DONE → uart_ctl stays 0 until the frame's ack; the next grant drives uart_ctl=5.
- Tx model holds data_valid=1 after the strobe, TIMEOUT=17'd50 → timeout_err pulses 50 cycles after ISSUE, no req_ack, and the next pending channel is granted.
- rst_n pulled low during WAIT_DONE → all outputs return to reset values asynchronously. After release, no grant until data_valid==1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one 7-bit UART transmitter among NUM_REQ requesters.
// Holds character and baud code for the whole frame; a watchdog aborts frames the transmitter never finishes.
module uart_tx_arbiter #(
    parameter int unsigned      NUM_REQ = 4,
    parameter int unsigned      IDX_W   = 2,
    parameter int unsigned      TO_W    = 17,
    parameter logic [TO_W-1:0]  TIMEOUT = 17'd100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic [2:0]           cfg_baud,
    output logic [2:0]           uart_ctl,
    output logic [6:0]           data_out,
    output logic                 data_sign,
    input  logic                 data_valid,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TIMEOUT - 1'b1;

    state_t           state, next_state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [TO_W-1:0]  wd_cnt;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [6:0]       sel_data;
    logic             waiting;
    logic             timeout_hit;
    logic             grant;

    // First asserted request at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int unsigned c;
        c         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            c = 32'(rr_ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!sel_found && req[c]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(c);
                sel_data  = req_data[7*c +: 7];
            end
        end
    end

    assign waiting     = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign timeout_hit = waiting && (wd_cnt == TO_LAST);
    assign grant       = (state == IDLE) && data_valid && sel_found;
    assign next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (grant) next_state = ISSUE;
            ISSUE:     next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (timeout_hit)      next_state = IDLE;
                else if (!data_valid) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (timeout_hit)     next_state = IDLE;
                else if (data_valid) next_state = DONE;
            end
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        data_sign   = (state == ISSUE);
        timeout_err = timeout_hit;
        req_ack     = '0;
        if (state == DONE) req_ack[grant_id] = 1'b1;
    end

    // Grant-time captures stay frozen until the next grant; the watchdog saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
            data_out <= '0;
            uart_ctl <= '0;
            rr_ptr   <= '0;
            wd_cnt   <= '0;
        end else begin
            if (grant) begin
                grant_id <= sel_idx;
                data_out <= sel_data;
                uart_ctl <= cfg_baud;
            end
            if (state == ISSUE)
                wd_cnt <= '0;
            else if (waiting && wd_cnt != TIMEOUT)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == DONE || timeout_hit)
                rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter with a transmitter model and a round-robin reference model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [27:0] req_data;
    logic [3:0]  req_ack;
    logic [2:0]  cfg_baud;
    logic [2:0]  uart_ctl;
    logic [6:0]  data_out;
    logic        data_sign;
    logic        data_valid;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    logic [6:0]  cd [4];
    int          passed = 0;
    int          total  = 0;
    int          m_ptr  = 0;
    int          tx_len = 10;
    bit          tx_hang = 1'b0;
    int          tx_left;

    assign req_data = {cd[3], cd[2], cd[1], cd[0]};

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .IDX_W   (2),
        .TO_W    (17),
        .TIMEOUT (17'd50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .cfg_baud    (cfg_baud),
        .uart_ctl    (uart_ctl),
        .data_out    (data_out),
        .data_sign   (data_sign),
        .data_valid  (data_valid),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // Transmitter: low the cycle after reset, drops after a strobe, rises tx_len cycles later.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            tx_left    <= 0;
        end else if (data_sign && !tx_hang) begin
            data_valid <= 1'b0;
            tx_left    <= tx_len;
        end else if (tx_left > 1) begin
            tx_left    <= tx_left - 1;
        end else begin
            tx_left    <= 0;
            data_valid <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/req_ack"},     req_ack,     0);
        chk({tag, "/uart_ctl"},    uart_ctl,    0);
        chk({tag, "/data_out"},    data_out,    0);
        chk({tag, "/data_sign"},   data_sign,   0);
        chk({tag, "/busy"},        busy,        0);
        chk({tag, "/grant_id"},    grant_id,    0);
        chk({tag, "/timeout_err"}, timeout_err, 0);
    endtask

    // One frame: the model predicts the granted channel, then timing, hold and ack are checked.
    task automatic run_frame(input string tag, input int len, input bit hang, input int mid_baud);
        int         exp_ch, n, extra;
        logic [6:0] exp_d;
        logic [2:0] exp_b;
        bit         hold_ok;
        exp_ch  = pick(req, m_ptr);
        exp_d   = cd[exp_ch];
        exp_b   = cfg_baud;
        tx_len  = len;
        tx_hang = hang;
        n = 0;
        while (data_sign !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/strobe"},   data_sign, 1);
        chk({tag, "/grant_id"}, grant_id,  exp_ch);
        chk({tag, "/data_out"}, data_out,  exp_d);
        chk({tag, "/uart_ctl"}, uart_ctl,  exp_b);
        n = 0; extra = 0; hold_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 3 && mid_baud >= 0) cfg_baud = 3'(mid_baud);
            if (data_sign !== 1'b0) extra++;
            if (data_out !== exp_d || uart_ctl !== exp_b || busy !== 1'b1) hold_ok = 1'b0;
        end while (req_ack === 4'b0 && timeout_err === 1'b0 && n < 200);
        chk({tag, "/hold"},         hold_ok, 1);
        chk({tag, "/extra_strobe"}, extra,   0);
        if (hang) begin
            chk({tag, "/timeout_err"}, timeout_err, 1);
            chk({tag, "/no_ack"},      req_ack,     0);
            chk({tag, "/to_cycles"},   n,           50);
        end else begin
            chk({tag, "/req_ack"},  req_ack,     4'b1 << exp_ch);
            chk({tag, "/no_to"},    timeout_err, 0);
            chk({tag, "/ack_time"}, n,           len + 1);
        end
        m_ptr   = (exp_ch + 1) % 4;
        tx_hang = 1'b0;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        req      = 4'b0001;
        cd[0]    = 7'h55; cd[1] = 7'h00; cd[2] = 7'h00; cd[3] = 7'h00;
        cfg_baud = 3'd4;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("boot/no_grant", busy, 0);

        run_frame("single", 40, 1'b0, -1);
        req = 4'b0000;
        @(negedge clk);
        chk("single/idle_busy", busy, 0);
        chk("single/idle_ack",  req_ack, 0);

        cd[0] = 7'h11; cd[1] = 7'h22; cd[2] = 7'h33; cd[3] = 7'h44;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_frame("all", $urandom_range(2, 40), 1'b0, -1);

        req = 4'b1001;
        run_frame("wrap_a", 8, 1'b0, -1);
        run_frame("wrap_b", 8, 1'b0, -1);

        cfg_baud = 3'd0;
        req = 4'b0010;
        run_frame("baud_mid", 30, 1'b0, 5);
        run_frame("baud_next", 12, 1'b0, -1);

        req = 4'b0011;
        run_frame("timeout", 10, 1'b1, -1);
        run_frame("after_to", 10, 1'b0, -1);
        run_frame("retry", 10, 1'b0, -1);

        req   = 4'b0100;
        cd[2] = 7'($urandom);
        tx_len = 20;
        n = 0;
        while (data_sign !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst/strobe", data_sign, 1);
        repeat (5) @(negedge clk);
        chk("rst/busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_async");
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
        chk("rst/no_grant", busy, 0);
        run_frame("after_rst", 15, 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            req      = 4'($urandom_range(1, 15));
            cfg_baud = 3'($urandom_range(0, 5));
            for (int c = 0; c < 4; c++) cd[c] = 7'($urandom);
            run_frame("rand", $urandom_range(2, 40), 1'b0, -1);
        end

        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("end/idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
